stg_seq: RTL
============

# stg_seq

Stage sequencer for the rk16 core. It drives the one-hot `stage` and `stg_clk` buses that step the four-stage datapath (fetch, decode, execute, writeback). It also holds the core in reset after power-up and adds host run/halt/single-step control plus a stall input for slow memory. It sits between the reset/host control logic and every stage-clocked register in the core.

## Interface
- `NSTG`, 4: number of pipeline stages; width of `stage`/`stg_clk`.
- `RST_WAIT`, 3: cycles `rst_core` stays high after `resetn` deasserts.
- `START_RUN`, 1: 1 = enter RUN after startup, 0 = enter HALT.
- `clk` in 1: system clock; only clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `run_req` in 1: level; request free-running execution.
- `halt_req` in 1: level; request halt at next instruction boundary.
- `step_req` in 1: pulse; execute exactly one instruction from HALT.
- `stall` in 1: hold the current stage; sampled in phase 0 only.
- `stage` out NSTG: one-hot active stage; 0 when not executing.
- `stg_clk` out NSTG: one-cycle one-hot strobe of the active stage.
- `rst_core` out 1: active-high core reset.
- `halted` out 1: high while in HALT.
- `step_ack` out 1: one-cycle pulse when a step completes.
- `instr_cnt` out 16: retired-instruction counter.

## Operation
- States:
  - INIT: startup; `rst_core`=1.
  - HALT: idle.
  - RUN: free-running execution.
  - STEP: executing one instruction.
- Internal stage index `sidx` (0..NSTG-1) and phase bit `ph`.
- Execution, in RUN or STEP only:
  - `stage` = 1<<`sidx`.
  - ph=0: if `stall`, hold; else ph→1.
  - ph=1: `stg_clk` = 1<<`sidx`, then ph→0 and `sidx`→`sidx`+1.
  - ph=1 is never held, so `stall` cannot widen the `stg_clk` strobe.
- Instruction boundary: ph=1 with `sidx`=NSTG-1. At the boundary:
  - `instr_cnt` increments, wrapping 0xFFFF→0x0000.
  - `sidx` wraps to 0.
- INIT:
  - Counter runs from 0 to RST_WAIT-1.
  - Then `rst_core`→0 and state → RUN if START_RUN, else HALT.
  - Control inputs are ignored in INIT.
- HALT:
  - Priority: `halt_req` > `step_req` > `run_req`.
  - `halt_req` high: stay in HALT, ignore the others.
  - `step_req` → STEP; `run_req` → RUN.
  - Entry from HALT always starts at `sidx`=0, ph=0.
- RUN:
  - Sampling `halt_req` high sets the sticky `halt_pend` flag.
  - At the boundary, `halt_pend` → HALT and clears the flag.
  - `run_req` low at the boundary with `halt_pend` clear also → HALT.
  - A running instruction is never aborted.
- STEP:
  - At the boundary → HALT and `step_ack`=1 for one cycle.
  - `step_req`, `run_req` and `halt_req` are ignored during STEP.
- `halted` = (state==HALT).
- `stage`=0 and `stg_clk`=0 outside RUN/STEP.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The partial instruction is discarded and `instr_cnt` clears.

## Timing
- Reset values:
  - `stage`=0, `stg_clk`=0.
  - `rst_core`=1, `halted`=0, `step_ack`=0.
  - `instr_cnt`=0, state=INIT.
- `rst_core` falls RST_WAIT rising edges after the first edge with `resetn` high.
- `stage`=0001 appears on the same edge that `rst_core` falls (START_RUN=1).
- Unstalled instruction: 2·NSTG cycles (8 by default).
  - `stg_clk` pulses on cycles 2, 4, 6, 8 of the instruction.
- Each cycle of `stall` high in ph=0 adds exactly one cycle.
- HALT→RUN/STEP:
  - Request sampled at edge N.
  - `stage`=0001 visible after edge N.
  - First `stg_clk` after edge N+1.
- RUN→HALT: `halted`=1 and `stage`=0 after the boundary edge.
- Halt latency: at most one instruction.
- STEP: `step_ack` and `halted` rise on the same edge.
- `instr_cnt` updates on the boundary edge, coincident with the last `stg_clk` falling.

## Test plan
- Power-up, START_RUN=1, `run_req`=1 → `rst_core` high 3 cycles; then `stage` sequence 0001,0001,0010,0010,0100,0100,1000,1000; `stg_clk`=0001 on cycle 2; `instr_cnt`=1 after 8 cycles.
- `stall` high 3 cycles during stage 0010 ph0 → that instruction takes 11 cycles; each `stg_clk` pulse stays exactly 1 cycle wide.
- `halt_req` pulsed mid-instruction (stage 0100) → instruction completes; `halted`=1 at boundary; `stage`=0; `instr_cnt` increments by exactly 1.
- From HALT, single-cycle `step_req`, with `run_req` high during the step → one instruction (8 cycles); `step_ack` pulse; back in HALT; `instr_cnt`+1.
- In HALT, `halt_req`, `step_req` and `run_req` all high together → remains HALT; `stage`=0.
- `resetn` low during stage 0100 of RUN → outputs go to reset values without waiting for `clk`; after release, 3-cycle INIT repeats.

Source files
------------

// File: rtl/stg_seq.sv
// Stage sequencer: one-hot stage/stg_clk stepping, power-up core reset, run/halt/step control.
// Two cycles per stage (one more per stalled ph0 cycle); halts only at instruction boundaries.
module stg_seq #(
    parameter int NSTG      = 4,
    parameter int RST_WAIT  = 3,
    parameter int START_RUN = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            run_req,
    input  logic            halt_req,
    input  logic            step_req,
    input  logic            stall,
    output logic [NSTG-1:0] stage,
    output logic [NSTG-1:0] stg_clk,
    output logic            rst_core,
    output logic            halted,
    output logic            step_ack,
    output logic [15:0]     instr_cnt
);

    localparam int SW = (NSTG > 1) ? $clog2(NSTG) : 1;
    localparam int RW = (RST_WAIT > 1) ? RST_WAIT : 1;
    localparam int CW = (RW > 1) ? $clog2(RW) : 1;
    localparam logic [SW-1:0]   SLAST = SW'(NSTG - 1);
    localparam logic [CW-1:0]   CLAST = CW'(RW - 1);
    localparam logic [NSTG-1:0] ONE   = NSTG'(1);

    typedef enum logic [1:0] {
        S_INIT,
        S_HALT,
        S_RUN,
        S_STEP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   sidx;
    logic            ph;
    logic [CW-1:0]   init_cnt;
    logic            halt_pend;
    logic            exec;
    logic            boundary;
    logic            init_done;
    logic            halt_now;

    assign exec      = (state == S_RUN) || (state == S_STEP);
    assign boundary  = exec && ph && (sidx == SLAST);
    assign init_done = (init_cnt == CLAST);
    // A request seen on the boundary cycle itself counts, keeping halt latency within one instruction.
    assign halt_now  = halt_pend || halt_req || !run_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: begin
                if (init_done) begin
                    state_nxt = (START_RUN != 0) ? S_RUN : S_HALT;
                end
            end
            S_HALT: begin
                if (halt_req) begin
                    state_nxt = S_HALT;
                end else if (step_req) begin
                    state_nxt = S_STEP;
                end else if (run_req) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (boundary && halt_now) begin
                    state_nxt = S_HALT;
                end
            end
            S_STEP: begin
                if (boundary) begin
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_cnt  <= '0;
            sidx      <= '0;
            ph        <= 1'b0;
            halt_pend <= 1'b0;
            step_ack  <= 1'b0;
            instr_cnt <= 16'd0;
        end else begin
            step_ack <= (state == S_STEP) && boundary;

            if ((state == S_INIT) && !init_done) begin
                init_cnt <= init_cnt + 1'b1;
            end

            // ph1 always advances, so a stall can only stretch the ph0 half of a stage.
            if (exec) begin
                if (!ph) begin
                    if (!stall) begin
                        ph <= 1'b1;
                    end
                end else begin
                    ph   <= 1'b0;
                    sidx <= (sidx == SLAST) ? '0 : sidx + 1'b1;
                end
            end else begin
                ph   <= 1'b0;
                sidx <= '0;
            end

            if (boundary) begin
                instr_cnt <= instr_cnt + 16'd1;
            end

            halt_pend <= (state == S_RUN) && !boundary && (halt_pend || halt_req);
        end
    end

    always_comb begin
        stage    = '0;
        stg_clk  = '0;
        rst_core = (state == S_INIT);
        halted   = (state == S_HALT);
        if (exec) begin
            stage = ONE << sidx;
            if (ph) begin
                stg_clk = ONE << sidx;
            end
        end
    end

endmodule
